// File: rtl/spw_tick_pkg.sv
// Shared definitions for the SpaceWire time-code tick scheduler: register map,
// CTRL bit positions, FSM encoding, period limits and small arithmetic helpers.
package spw_tick_pkg;

    localparam int unsigned CTR_W = 32;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_TIME   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_AUTOINC_BIT = 1;
    localparam int unsigned CTRL_TRIG_BIT    = 2;

    // Smallest interval the reload-on-expire scheme can honour exactly.
    localparam logic [CTR_W-1:0] DEFAULT_MIN_PERIOD = 32'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ISSUE = 2'd2
    } tick_state_e;

    typedef struct packed {
        logic [1:0] flags;
        logic [5:0] count;
    } time_code_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Count wraps 63->0 while the flag bits ride along untouched.
    function automatic time_code_t time_code_inc(input time_code_t t);
        time_code_t r;
        r       = t;
        r.count = t.count + 6'd1;
        return r;
    endfunction

    function automatic logic [CTR_W-1:0] clamp_period(input logic [CTR_W-1:0] v,
                                                      input logic [CTR_W-1:0] min_p);
        return (v < min_p) ? min_p : v;
    endfunction

endpackage

// File: rtl/spw_tick_period_ctr.sv
// Loadable period down-counter; expire flags the last cycle of an interval.
// Loading zero parks the counter until the next load.
module spw_tick_period_ctr
    import spw_tick_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CTR_W-1:0] value,
    input  logic             run,
    output logic             expire
);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (run && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: state flops use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == {{(CTR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/spw_tick_scheduler.sv
// Avalon-MM programmable SpaceWire time-code scheduler: issues periodic or
// software-triggered tick_in pulses to the CODEC and tracks sent/missed ticks.
module spw_tick_scheduler
    import spw_tick_pkg::*;
#(
    parameter logic [31:0] PERIOD_RESET = 32'd1000,
    parameter logic [31:0] MIN_PERIOD   = DEFAULT_MIN_PERIOD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        link_running,
    output logic        tick_in,
    output logic [7:0]  time_in
);

    tick_state_e state_q, state_d;
    logic        ctrl_en_q, ctrl_en_d;
    logic        ctrl_autoinc_q, ctrl_autoinc_d;
    logic        trig_q, trig_d;
    logic [31:0] period_q, period_d;
    time_code_t  time_q, time_d;
    logic [15:0] sent_q, sent_d;
    logic [15:0] missed_q, missed_d;
    logic        tick_in_q, tick_in_d;
    logic [7:0]  time_in_q, time_in_d;

    logic        wr_strobe;
    logic        wr_ctrl, wr_period, wr_time, wr_status;
    logic        en_on, en_off;
    logic        ctr_load, ctr_run, ctr_expire;
    logic [31:0] ctr_value;
    logic        periodic_fire;
    logic        fire, sent_now;

    assign wr_strobe = chipselect & ~write_n;
    assign wr_ctrl   = wr_strobe & (address == ADDR_CTRL);
    assign wr_period = wr_strobe & (address == ADDR_PERIOD);
    assign wr_time   = wr_strobe & (address == ADDR_TIME);
    assign wr_status = wr_strobe & (address == ADDR_STATUS);
    assign en_on     = wr_ctrl & writedata[CTRL_EN_BIT];
    assign en_off    = wr_ctrl & ~writedata[CTRL_EN_BIT];

    spw_tick_period_ctr u_period_ctr (
        .clk    (clk),
        .reset  (reset),
        .load   (ctr_load),
        .value  (ctr_value),
        .run    (ctr_run),
        .expire (ctr_expire)
    );

    // Reloading at the expiry edge and still decrementing in ISSUE keeps the
    // tick-to-tick spacing equal to PERIOD rather than PERIOD+1.
    always_comb begin
        state_d       = state_q;
        ctr_load      = 1'b0;
        ctr_value     = '0;
        ctr_run       = 1'b0;
        periodic_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_on) begin
                    state_d   = ST_COUNT;
                    ctr_load  = 1'b1;
                    ctr_value = period_q;
                end
            end
            ST_COUNT: begin
                if (en_off) begin
                    state_d  = ST_IDLE;
                    ctr_load = 1'b1;
                end else if (ctr_expire) begin
                    state_d       = ST_ISSUE;
                    ctr_load      = 1'b1;
                    ctr_value     = period_q;
                    periodic_fire = 1'b1;
                end else begin
                    ctr_run = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (en_off) begin
                    state_d  = ST_IDLE;
                    ctr_load = 1'b1;
                end else begin
                    state_d = ST_COUNT;
                    ctr_run = 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                ctr_load = 1'b1;
            end
        endcase
    end

    // A pending TRIG and a periodic expiry on the same edge merge into one tick.
    always_comb begin
        fire           = periodic_fire | trig_q;
        sent_now       = fire & link_running;
        ctrl_en_d      = ctrl_en_q;
        ctrl_autoinc_d = ctrl_autoinc_q;
        trig_d         = wr_ctrl & writedata[CTRL_TRIG_BIT];
        period_d       = period_q;
        time_d         = time_q;
        sent_d         = sent_q;
        missed_d       = missed_q;
        tick_in_d      = sent_now;
        time_in_d      = 8'h00;

        if (sent_now) begin
            time_in_d = time_q;
        end
        if (wr_ctrl) begin
            ctrl_en_d      = writedata[CTRL_EN_BIT];
            ctrl_autoinc_d = writedata[CTRL_AUTOINC_BIT];
        end
        if (wr_period) begin
            period_d = clamp_period(writedata, MIN_PERIOD);
        end
        if (wr_time) begin
            time_d = time_code_t'(writedata[7:0]);
        end else if (sent_now && ctrl_autoinc_q) begin
            time_d = time_code_inc(time_q);
        end
        if (wr_status) begin
            sent_d   = '0;
            missed_d = '0;
        end else if (sent_now) begin
            sent_d = sat_inc16(sent_q);
        end else if (fire) begin
            missed_d = sat_inc16(missed_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            ctrl_en_q      <= 1'b0;
            ctrl_autoinc_q <= 1'b0;
            trig_q         <= 1'b0;
            period_q       <= PERIOD_RESET;
            time_q         <= '0;
            sent_q         <= '0;
            missed_q       <= '0;
            tick_in_q      <= 1'b0;
            time_in_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            ctrl_en_q      <= ctrl_en_d;
            ctrl_autoinc_q <= ctrl_autoinc_d;
            trig_q         <= trig_d;
            period_q       <= period_d;
            time_q         <= time_d;
            sent_q         <= sent_d;
            missed_q       <= missed_d;
            tick_in_q      <= tick_in_d;
            time_in_q      <= time_in_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CTRL:   readdata = {29'd0, 1'b0, ctrl_autoinc_q, ctrl_en_q};
            ADDR_PERIOD: readdata = period_q;
            ADDR_TIME:   readdata = {24'd0, time_q};
            ADDR_STATUS: readdata = {missed_q, sent_q};
            default:     readdata = '0;
        endcase
    end

    assign tick_in = tick_in_q;
    assign time_in = time_in_q;

endmodule

// File: tb/tb_spw_tick_scheduler.sv
// Self-checking bench for spw_tick_scheduler: directed scenarios plus a
// randomized run against an event-schedule reference model.
module tb_spw_tick_scheduler;
    import spw_tick_pkg::*;

    localparam logic [31:0] P_RESET = 32'd1000;
    localparam int unsigned P_MIN   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        link_running;
    logic        tick_in;
    logic [7:0]  time_in;

    always #5 clk = ~clk;

    spw_tick_scheduler #(
        .PERIOD_RESET (P_RESET),
        .MIN_PERIOD   (32'd2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .link_running (link_running),
        .tick_in      (tick_in),
        .time_in      (time_in)
    );

    int n_tests;
    int n_fail;
    int edge_n;

    // Reference model: registers plus the absolute edge of the next periodic tick.
    bit          m_en, m_autoinc, m_trig_pending;
    int unsigned m_period;
    int          m_time, m_sent, m_missed;
    longint      m_next_due;
    bit          exp_tick;
    int          exp_time;

    task automatic model_edge();
        bit          wr, periodic, fire, is_ctrl;
        logic [31:0] data;
        wr      = chipselect && !write_n;
        data    = writedata;
        is_ctrl = wr && (address == ADDR_CTRL);
        if (reset) begin
            m_en = 0; m_autoinc = 0; m_trig_pending = 0;
            m_period = P_RESET; m_time = 0; m_sent = 0; m_missed = 0;
            m_next_due = -1; exp_tick = 0; exp_time = 0;
            return;
        end
        periodic = m_en && (m_next_due == longint'(edge_n)) && !(is_ctrl && !data[0]);
        fire     = periodic || m_trig_pending;
        exp_tick = fire && link_running;
        exp_time = exp_tick ? m_time : 0;

        if (is_ctrl && !data[0])           m_next_due = -1;
        else if (periodic)                 m_next_due = longint'(edge_n) + longint'(m_period);
        else if (is_ctrl && data[0] && !m_en) m_next_due = longint'(edge_n) + longint'(m_period);

        if (wr && address == ADDR_STATUS) begin
            m_sent = 0; m_missed = 0;
        end else if (exp_tick) begin
            m_sent = (m_sent == 65535) ? 65535 : m_sent + 1;
        end else if (fire) begin
            m_missed = (m_missed == 65535) ? 65535 : m_missed + 1;
        end

        if (wr && address == ADDR_TIME)   m_time = int'(data & 32'hFF);
        else if (exp_tick && m_autoinc)   m_time = (m_time & 'hC0) | ((m_time + 1) & 'h3F);

        if (is_ctrl) begin
            m_en = data[0]; m_autoinc = data[1];
        end
        m_trig_pending = is_ctrl && data[2];
        if (wr && address == ADDR_PERIOD) m_period = (data < P_MIN) ? P_MIN : data;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            ADDR_CTRL:   return {30'd0, m_autoinc, m_en};
            ADDR_PERIOD: return m_period;
            ADDR_TIME:   return 32'(m_time);
            default:     return {16'(m_missed), 16'(m_sent)};
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic set_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] d);
        set_write(a, d);
        step();
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [31:0] exp_rst [4];
        exp_rst = '{32'd0, P_RESET, 32'd0, 32'd0};
        do_reset();
        n_tests++;
        if (tick_in !== 1'b0) begin n_fail++; $display("FAIL reset_tick_in: got %b want 0", tick_in); end
        n_tests++;
        if (time_in !== 8'h00) begin n_fail++; $display("FAIL reset_time_in: got %h want 00", time_in); end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            n_tests++;
            if (rd !== exp_rst[a]) begin
                n_fail++; $display("FAIL reset_reg%0d: got %h want %h", a, rd, exp_rst[a]);
            end
        end
    endtask

    // PERIOD=5, EN written at edge 10 after reset -> ticks at edges 15, 20, 25.
    task automatic test_periodic();
        int  base, rel;
        bit  want;
        do_reset();
        base = edge_n;
        link_running = 1'b1;
        do_write(ADDR_PERIOD, 32'd5);
        while (edge_n - base < 9) step();
        do_write(ADDR_CTRL, 32'h1);
        while (edge_n - base < 26) begin
            step();
            rel  = edge_n - base;
            want = (rel == 15) || (rel == 20) || (rel == 25);
            n_tests++;
            if (tick_in !== want) begin
                n_fail++; $display("FAIL periodic_tick@%0d: got %b want %b", rel, tick_in, want);
            end
            n_tests++;
            if (time_in !== 8'h00) begin
                n_fail++; $display("FAIL periodic_time@%0d: got %h want 00", rel, time_in);
            end
        end
    endtask

    task automatic test_autoinc_wrap();
        logic [31:0] rd;
        do_reset();
        link_running = 1'b1;
        do_write(ADDR_TIME, 32'hBF);
        do_write(ADDR_CTRL, 32'h6);
        step();
        n_tests++;
        if (tick_in !== 1'b1) begin n_fail++; $display("FAIL wrap_tick: got %b want 1", tick_in); end
        n_tests++;
        if (time_in !== 8'hBF) begin n_fail++; $display("FAIL wrap_time_in: got %h want bf", time_in); end
        read_reg(ADDR_TIME, rd);
        n_tests++;
        if (rd !== 32'h80) begin n_fail++; $display("FAIL wrap_time_reg: got %h want 00000080", rd); end
        step();
        n_tests++;
        if (tick_in !== 1'b0 || time_in !== 8'h00) begin
            n_fail++; $display("FAIL wrap_idle: got %b/%h want 0/00", tick_in, time_in);
        end
        // TIME write lands on the same edge as an auto-increment: the write wins.
        do_write(ADDR_CTRL, 32'h6);
        do_write(ADDR_TIME, 32'h15);
        n_tests++;
        if (tick_in !== 1'b1 || time_in !== 8'h80) begin
            n_fail++; $display("FAIL collide_tick: got %b/%h want 1/80", tick_in, time_in);
        end
        read_reg(ADDR_TIME, rd);
        n_tests++;
        if (rd !== 32'h15) begin n_fail++; $display("FAIL collide_time_reg: got %h want 00000015", rd); end
        read_reg(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== 32'h2) begin n_fail++; $display("FAIL collide_status: got %h want 00000002", rd); end
    endtask

    task automatic test_link_down();
        logic [31:0] rd;
        do_reset();
        link_running = 1'b0;
        do_write(ADDR_PERIOD, 32'd4);
        do_write(ADDR_CTRL, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_tests++;
            if (tick_in !== 1'b0) begin n_fail++; $display("FAIL linkdown_tick@%0d: got %b want 0", k, tick_in); end
        end
        read_reg(ADDR_STATUS, rd);
        n_tests++;
        if (rd !== 32'h0003_0000) begin n_fail++; $display("FAIL linkdown_status: got %h want 00030000", rd); end
        read_reg(ADDR_TIME, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL linkdown_time: got %h want 00000000", rd); end
    endtask

    // PERIOD=6: the counter reaches its last count at edge E+5; TRIG written there.
    task automatic test_trig_collide();
        logic [31:0] rd;
        bit          want;
        do_reset();
        link_running = 1'b1;
        do_write(ADDR_PERIOD, 32'd6);
        do_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 12; k++) begin
            if (k == 5) set_write(ADDR_CTRL, 32'h5);
            step();
            want = (k == 6) || (k == 12);
            n_tests++;
            if (tick_in !== want) begin n_fail++; $display("FAIL trigcol_tick@%0d: got %b want %b", k, tick_in, want); end
            if (k == 6) begin
                read_reg(ADDR_STATUS, rd);
                n_tests++;
                if (rd !== 32'h1) begin n_fail++; $display("FAIL trigcol_sent: got %h want 00000001", rd); end
            end
        end
    endtask

    task automatic test_period_write();
        logic [31:0] rd;
        bit          want;
        do_reset();
        do_write(ADDR_PERIOD, 32'd0);
        read_reg(ADDR_PERIOD, rd);
        n_tests++;
        if (rd !== 32'd2) begin n_fail++; $display("FAIL period_zero: got %h want 00000002", rd); end
        do_write(ADDR_PERIOD, 32'd1);
        read_reg(ADDR_PERIOD, rd);
        n_tests++;
        if (rd !== 32'd2) begin n_fail++; $display("FAIL period_one: got %h want 00000002", rd); end
        link_running = 1'b1;
        do_write(ADDR_PERIOD, 32'd5);
        do_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 19; k++) begin
            if (k == 7) set_write(ADDR_PERIOD, 32'd8);
            step();
            want = (k == 5) || (k == 10) || (k == 18);
            n_tests++;
            if (tick_in !== want) begin n_fail++; $display("FAIL period_mid@%0d: got %b want %b", k, tick_in, want); end
        end
    endtask

    task automatic test_en_off();
        logic [31:0] rd;
        do_reset();
        link_running = 1'b1;
        do_write(ADDR_PERIOD, 32'd4);
        do_write(ADDR_CTRL, 32'h1);
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) set_write(ADDR_CTRL, 32'h0);
            step();
            n_tests++;
            if (tick_in !== 1'b0) begin n_fail++; $display("FAIL enoff_tick@%0d: got %b want 0", k, tick_in); end
        end
        do_write(ADDR_CTRL, 32'h4);
        step();
        n_tests++;
        if (tick_in !== 1'b1) begin n_fail++; $display("FAIL enoff_trig: got %b want 1", tick_in); end
        step();
        n_tests++;
        if (tick_in !== 1'b0) begin n_fail++; $display("FAIL enoff_trig_end: got %b want 0", tick_in); end
        read_reg(ADDR_CTRL, rd);
        n_tests++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL enoff_ctrl: got %h want 00000000", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [31:0] exp_rst [4];
        exp_rst = '{32'd0, P_RESET, 32'd0, 32'd0};
        do_reset();
        link_running = 1'b1;
        do_write(ADDR_PERIOD, 32'd5);
        do_write(ADDR_CTRL, 32'h3);
        for (int k = 1; k <= 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_tests++;
        if (tick_in !== 1'b0 || time_in !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_tick: got %b/%h want 0/00", tick_in, time_in);
        end
        for (int a = 0; a < 4; a++) begin
            read_reg(2'(a), rd);
            n_tests++;
            if (rd !== exp_rst[a]) begin
                n_fail++; $display("FAIL rstmid_reg%0d: got %h want %h", a, rd, exp_rst[a]);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            n_tests++;
            if (tick_in !== 1'b0) begin n_fail++; $display("FAIL rstmid_after@%0d: got %b want 0", k, tick_in); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ctrl;
        logic [1:0]  a;
        int unsigned r;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            link_running = ($urandom_range(0, 7) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) begin
                set_write(ADDR_PERIOD, $urandom_range(0, 9));
            end else if (r == 1) begin
                ctrl = {29'd0, ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 3) != 0)};
                set_write(ADDR_CTRL, ctrl);
            end else if (r == 2) begin
                set_write(ADDR_TIME, $urandom_range(0, 255));
            end else if (r == 3 && $urandom_range(0, 3) == 0) begin
                set_write(ADDR_STATUS, $urandom);
            end
            step();
            n_tests++;
            if (tick_in !== exp_tick || time_in !== 8'(exp_time)) begin
                n_fail++;
                $display("FAIL rand_out@%0d: got %b/%h want %b/%h", c, tick_in, time_in, exp_tick, 8'(exp_time));
            end
            a = 2'($urandom_range(0, 3));
            read_reg(a, rd);
            n_tests++;
            if (rd !== model_read(a)) begin
                n_fail++; $display("FAIL rand_reg%0d@%0d: got %h want %h", a, c, rd, model_read(a));
            end
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0; edge_n = 0;
        reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = 32'd0; link_running = 1'b0;
        test_reset();
        test_periodic();
        test_autoinc_wrap();
        test_link_down();
        test_trig_collide();
        test_period_write();
        test_en_off();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
